// File: rtl/stopwatch_timebase_ctrl.sv
// Stopwatch timebase: one-second prescaler, mm:ss counter with wrap, single-entry lap register.
// Latency: tick and updated time appear one cycle after the prescaler's last count; lap_valid one cycle after lap.
// Backpressure: lap register holds one value until lap_ack; a lap arriving while full is dropped with lap_miss.
module stopwatch_timebase_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int MAX_MIN  = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic       lap,
  input  logic       lap_ack,
  output logic       tick,
  output logic [5:0] seconds,
  output logic [6:0] minutes,
  output logic       lap_valid,
  output logic [5:0] lap_seconds,
  output logic [6:0] lap_minutes,
  output logic       lap_miss,
  output logic       overflow
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [6:0]    MIN_LAST = 7'(MAX_MIN);

  typedef enum logic {
    LAP_EMPTY = 1'b0,
    LAP_FULL  = 1'b1
  } lap_state_t;

  logic [PW-1:0] prescaler;
  logic          tick_now;
  lap_state_t    lap_state;
  lap_state_t    lap_state_nxt;
  logic          lap_take;
  logic          lap_drop;

  // A second elapses on the edge where an enabled prescaler sits on its last count.
  assign tick_now = enable && (prescaler == PRE_LAST);

  // Prescaler only advances while enabled, so pausing keeps the sub-second fraction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (clear) begin
      prescaler <= '0;
    end else if (enable) begin
      prescaler <= tick_now ? '0 : prescaler + PRE_ONE;
    end
  end

  // Time counter and tick pulse update together; wrap past MAX_MIN:59 latches overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick     <= 1'b0;
      seconds  <= '0;
      minutes  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      tick     <= 1'b0;
      seconds  <= '0;
      minutes  <= '0;
      overflow <= 1'b0;
    end else begin
      tick <= tick_now;
      if (tick_now) begin
        if (seconds == 6'd59) begin
          seconds <= '0;
          if (minutes == MIN_LAST) begin
            minutes  <= '0;
            overflow <= 1'b1;
          end else begin
            minutes <= minutes + 7'd1;
          end
        end else begin
          seconds <= seconds + 6'd1;
        end
      end
    end
  end

  // Lap FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_state <= LAP_EMPTY;
    end else begin
      lap_state <= lap_state_nxt;
    end
  end

  // Lap FSM next state: capture when empty or when a pop coincides with a new lap; drop otherwise.
  always_comb begin
    lap_state_nxt = lap_state;
    lap_take      = 1'b0;
    lap_drop      = 1'b0;
    if (clear) begin
      lap_state_nxt = LAP_EMPTY;
    end else begin
      case (lap_state)
        LAP_EMPTY: begin
          if (lap) begin
            lap_state_nxt = LAP_FULL;
            lap_take      = 1'b1;
          end
        end
        LAP_FULL: begin
          if (lap && lap_ack) begin
            lap_take = 1'b1;
          end else if (lap) begin
            lap_drop = 1'b1;
          end else if (lap_ack) begin
            lap_state_nxt = LAP_EMPTY;
          end
        end
        default: lap_state_nxt = LAP_EMPTY;
      endcase
    end
  end

  // Lap FSM output decode straight from the state register.
  always_comb begin
    lap_valid = (lap_state == LAP_FULL);
  end

  // Lap data samples the pre-increment time; miss pulse lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_seconds <= '0;
      lap_minutes <= '0;
      lap_miss    <= 1'b0;
    end else if (clear) begin
      lap_seconds <= '0;
      lap_minutes <= '0;
      lap_miss    <= 1'b0;
    end else begin
      lap_miss <= lap_drop;
      if (lap_take) begin
        lap_seconds <= seconds;
        lap_minutes <= minutes;
      end
    end
  end

endmodule
